acc_alu_seq: RTL and testbench

Parametrised accumulator/ALU datapath: WIDTH-bit accumulator, 3-bit function select, registered carry/zero flags and a valid/ready operand handshake. Extends the lab accumulator+ALU with generic width, shift ops and a multi-cycle shift-add multiply sequenced by an FSM. Sits between the operand/instruction source and the shared data bus of the lab CPU datapath.

---
 rtl/acc_alu_pkg.sv | 16 +
 rtl/acc_alu_core.sv | 51 +++++
 rtl/acc_alu_seq.sv | 117 +++++++++++
 tb/tb_acc_alu_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_alu_pkg.sv
// Shared opcode and sequencer-state encodings for the accumulator/ALU datapath.
package acc_alu_pkg;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_LOAD = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_SHR  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

endpackage

// File: rtl/acc_alu_core.sv
// Single-cycle combinational ALU: every op except MUL, which the sequencer iterates.
module acc_alu_core
    import acc_alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       F,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] oprnd,
    output logic [WIDTH-1:0] y,
    output logic             carry
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    // The extra top bit holds carry-out for ADD and borrow for SUB.
    assign w_sum  = {1'b0, acc} + {1'b0, oprnd};
    assign w_diff = {1'b0, acc} - {1'b0, oprnd};

    always_comb begin
        y     = '0;
        carry = 1'b0;
        case (F)
            OP_PASS: y = acc;
            OP_SUB: begin
                y     = w_diff[WIDTH-1:0];
                carry = w_diff[WIDTH];
            end
            OP_LOAD: y = oprnd;
            OP_ADD: begin
                y     = w_sum[WIDTH-1:0];
                carry = w_sum[WIDTH];
            end
            OP_NAND: y = ~(acc & oprnd);
            OP_SHL: begin
                y     = {acc[WIDTH-2:0], 1'b0};
                carry = acc[WIDTH-1];
            end
            OP_SHR: begin
                y     = {1'b0, acc[WIDTH-1:1]};
                carry = acc[0];
            end
            default: begin
                y     = '0;
                carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/acc_alu_seq.sv
// Accumulator/ALU with valid/ready operand intake and a WIDTH-step shift-add multiplier.
// state   | meaning
// ST_IDLE | accepting operands; non-MUL ops complete on the accepting edge
// ST_MUL  | one shift-add step per edge until the step counter hits 0
module acc_alu_seq
    import acc_alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             resetA,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       F,
    input  logic [WIDTH-1:0] OPRND,
    input  logic             acc_we,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic [WIDTH-1:0] ACU,
    output logic             CARRY,
    output logic             ZERO,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [0:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_prod;
    logic               r_we;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry;
    logic               r_zero;
    logic               r_out_valid;

    logic [WIDTH-1:0]   w_y;
    logic               w_c;
    logic [2*WIDTH-1:0] w_prod_next;
    logic               w_last;

    acc_alu_core #(.WIDTH(WIDTH)) u_core (
        .F     (F),
        .acc   (r_acc),
        .oprnd (OPRND),
        .y     (w_y),
        .carry (w_c)
    );

    assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);
    // Counter is about to reach terminal count on this edge.
    assign w_last      = (r_cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge resetA) begin
        if (!resetA) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_prod      <= '0;
            r_we        <= 1'b0;
            r_acc       <= '0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (F == OP_MUL) begin
                            r_mcand  <= {{WIDTH{1'b0}}, r_acc};
                            r_mplier <= OPRND;
                            r_prod   <= '0;
                            r_we     <= acc_we;
                            r_cnt    <= CNT_W'(WIDTH);
                            r_state  <= ST_MUL;
                        end else begin
                            r_result    <= w_y;
                            r_carry     <= w_c;
                            r_zero      <= (w_y == '0);
                            r_out_valid <= 1'b1;
                            if (acc_we) r_acc <= w_y;
                        end
                    end
                end
                default: begin
                    r_prod   <= w_prod_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - CNT_W'(1);
                    if (w_last) begin
                        // Low half is the result; any set bit in the high half is overflow.
                        r_result    <= w_prod_next[WIDTH-1:0];
                        r_carry     <= |w_prod_next[2*WIDTH-1:WIDTH];
                        r_zero      <= (w_prod_next[WIDTH-1:0] == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= ST_IDLE;
                        if (r_we) r_acc <= w_prod_next[WIDTH-1:0];
                    end
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE) & resetA;
    assign busy      = (r_state == ST_MUL);
    assign result    = r_result;
    assign out_valid = r_out_valid;
    assign ACU       = r_acc;
    assign CARRY     = r_carry;
    assign ZERO      = r_zero;

endmodule

// File: tb/tb_acc_alu_seq.sv
// Self-checking bench for acc_alu_seq against an arithmetic reference model.
module tb_acc_alu_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         resetA;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   F;
    logic [W-1:0] OPRND;
    logic         acc_we;
    logic [W-1:0] result;
    logic         out_valid;
    logic [W-1:0] ACU;
    logic         CARRY;
    logic         ZERO;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] acc_m, res_m;
    logic         c_m, z_m;

    acc_alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .resetA    (resetA),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .F         (F),
        .OPRND     (OPRND),
        .acc_we    (acc_we),
        .result    (result),
        .out_valid (out_valid),
        .ACU       (ACU),
        .CARRY     (CARRY),
        .ZERO      (ZERO),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Returns {carry, y} computed from plain integer arithmetic.
    function automatic int ref_op(input int f, input int a, input int b);
        int mask, y, c, p;
        mask = (1 << W) - 1;
        y = 0;
        c = 0;
        case (f)
            0: y = a;
            1: begin y = (a - b) & mask; c = (a < b) ? 1 : 0; end
            2: y = b;
            3: begin p = a + b; y = p & mask; c = (p > mask) ? 1 : 0; end
            4: y = (~(a & b)) & mask;
            5: begin y = (a * 2) & mask; c = (a >= (1 << (W - 1))) ? 1 : 0; end
            6: begin y = a / 2; c = a % 2; end
            default: begin p = a * b; y = p & mask; c = (p > mask) ? 1 : 0; end
        endcase
        return (c << W) | y;
    endfunction

    function automatic void model_reset();
        acc_m = '0;
        res_m = '0;
        c_m   = 1'b0;
        z_m   = 1'b0;
    endfunction

    // Called just after a falling edge; returns just after a falling edge.
    task automatic issue(input logic [2:0] f, input logic [W-1:0] opr, input logic we, input string name);
        int r, n;
        logic [W-1:0] ey;
        logic ec;
        r  = ref_op(int'(f), int'(acc_m), int'(opr));
        ey = r[W-1:0];
        ec = r[W];
        F = f; OPRND = opr; acc_we = we; in_valid = 1'b1;
        @(negedge clk);
        if (f == 3'b111) begin
            n = 0;
            while (out_valid !== 1'b1 && n < 50) begin
                checks++;
                if ({in_ready, busy, out_valid} !== 3'b010) begin
                    failures++;
                    $display("FAIL %s busy-phase got ready/busy/ov=%b%b%b exp=010", name, in_ready, busy, out_valid);
                end
                in_valid = 1'($urandom);
                F        = 3'($urandom);
                OPRND    = W'($urandom);
                acc_we   = 1'($urandom);
                @(negedge clk);
                n++;
            end
            checks++;
            if (n != W) begin
                failures++;
                $display("FAIL %s mul-latency got=%0d exp=%0d", name, n, W);
            end
        end
        in_valid = 1'b0;
        res_m = ey;
        c_m   = ec;
        z_m   = (ey == '0);
        if (we) acc_m = ey;
        checks++;
        if ({out_valid, in_ready, busy, result, CARRY, ZERO, ACU} !== {1'b1, 1'b1, 1'b0, res_m, c_m, z_m, acc_m}) begin
            failures++;
            $display("FAIL %s got ov=%b rdy=%b busy=%b res=%b C=%b Z=%b ACU=%b exp ov=1 rdy=1 busy=0 res=%b C=%b Z=%b ACU=%b",
                     name, out_valid, in_ready, busy, result, CARRY, ZERO, ACU, res_m, c_m, z_m, acc_m);
        end
    endtask

    task automatic idle_check(input string name);
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready, busy, result, CARRY, ZERO, ACU} !== {1'b0, 1'b1, 1'b0, res_m, c_m, z_m, acc_m}) begin
            failures++;
            $display("FAIL %s idle got ov=%b rdy=%b busy=%b res=%b C=%b Z=%b ACU=%b exp ov=0 rdy=1 busy=0 res=%b C=%b Z=%b ACU=%b",
                     name, out_valid, in_ready, busy, result, CARRY, ZERO, ACU, res_m, c_m, z_m, acc_m);
        end
    endtask

    task automatic test_reset();
        issue(3'b010, 4'b0111, 1'b1, "pre_reset_load");
        #2 resetA = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({ACU, result, CARRY, ZERO, busy, out_valid} !== {acc_m, res_m, 4'b0}) begin
            failures++;
            $display("FAIL reset_immediate got ACU=%b res=%b C=%b Z=%b busy=%b ov=%b exp all zero",
                     ACU, result, CARRY, ZERO, busy, out_valid);
        end
        @(negedge clk);
        resetA = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got=%b exp=1", in_ready);
        end
        idle_check("reset_idle");
    endtask

    task automatic test_back_to_back();
        issue(3'b010, 4'b1010, 1'b1, "b2b_load");
        issue(3'b011, 4'b1010, 1'b1, "b2b_add");
        idle_check("b2b_after");
    endtask

    task automatic test_sub();
        issue(3'b010, 4'b0100, 1'b1, "sub_setup");
        issue(3'b001, 4'b0100, 1'b1, "sub_zero");
        issue(3'b001, 4'b0001, 1'b1, "sub_borrow");
    endtask

    task automatic test_mul();
        issue(3'b010, 4'b0011, 1'b1, "mul_setup1");
        issue(3'b111, 4'b0101, 1'b1, "mul_3x5");
        issue(3'b010, 4'b0110, 1'b1, "mul_setup2");
        issue(3'b111, 4'b0011, 1'b1, "mul_6x3");
        issue(3'b111, 4'b0111, 1'b0, "mul_no_we");
        idle_check("mul_after");
    endtask

    task automatic test_logic_shift();
        issue(3'b010, 4'b1010, 1'b1, "nand_setup");
        issue(3'b100, 4'b1111, 1'b0, "nand_no_we");
        issue(3'b010, 4'b1001, 1'b1, "shift_setup");
        issue(3'b101, 4'b0000, 1'b1, "shl");
        issue(3'b110, 4'b0000, 1'b1, "shr");
        issue(3'b000, 4'b1111, 1'b1, "pass");
    endtask

    task automatic test_reset_mid_mul();
        issue(3'b010, 4'b0011, 1'b1, "rmul_setup");
        F = 3'b111; OPRND = 4'b0101; acc_we = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2 resetA = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({ACU, result, CARRY, ZERO, busy, out_valid} !== {acc_m, res_m, 4'b0}) begin
            failures++;
            $display("FAIL rmul_abort got ACU=%b res=%b C=%b Z=%b busy=%b ov=%b exp all zero",
                     ACU, result, CARRY, ZERO, busy, out_valid);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL rmul_held got ov=%b busy=%b exp 00", out_valid, busy);
        end
        resetA = 1'b1;
        issue(3'b010, 4'b0001, 1'b1, "rmul_load_after");
        idle_check("rmul_idle");
    endtask

    task automatic test_random();
        logic [2:0] f;
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom);
            issue(f, W'($urandom), 1'($urandom_range(3, 0) != 0), $sformatf("rand_%0d_f%0d", i, f));
            if ($urandom_range(3, 0) == 0) idle_check($sformatf("rand_idle_%0d", i));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        resetA = 1'b0;
        in_valid = 1'b0;
        F = '0;
        OPRND = '0;
        acc_we = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({ACU, result, CARRY, ZERO, busy, out_valid} !== 12'b0) begin
            failures++;
            $display("FAIL por_state got ACU=%b res=%b C=%b Z=%b busy=%b ov=%b exp all zero",
                     ACU, result, CARRY, ZERO, busy, out_valid);
        end
        resetA = 1'b1;
        test_reset();
        test_back_to_back();
        test_sub();
        test_mul();
        test_logic_shift();
        test_reset_mid_mul();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
